// File: rtl/sh7034_intc_if.sv
// ---------------------------------------------------------------------------
// sh7034_intc_if -- IBUS slave port bundle for the SH7034 interrupt controller.
//
// Signals
//   IBUS_A     byte address (28 bits)
//   IBUS_DI    write data, big-endian lanes ([31:24] = lane 3)
//   IBUS_DO    read data, 0 when the slave is not selected
//   IBUS_BA    byte enables ([3] = MSB lane)
//   IBUS_WE    write strobe
//   IBUS_REQ   bus request
//   IBUS_BUSY  slave stall (this slave never stalls)
//   IBUS_ACT   address falls inside the slave's window
//
// Handshake: the master holds IBUS_REQ with a stable address/strobe; a
// transfer completes on every clock-enabled edge where IBUS_REQ=1 and
// IBUS_BUSY=0. Writes commit on the rising enable; read data is latched on
// the falling enable and is valid on IBUS_DO while IBUS_REQ stays high.
// ---------------------------------------------------------------------------
interface sh7034_intc_if;
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (
        output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        input  IBUS_DO, IBUS_BUSY, IBUS_ACT
    );

    modport slave (
        input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
        output IBUS_DO, IBUS_BUSY, IBUS_ACT
    );
endinterface

// File: rtl/sh7034_intc.sv
// ---------------------------------------------------------------------------
// sh7034_intc -- SH7034 on-chip interrupt controller.
//
// Collects NMI, IRQ0-7 and the TEI/TXI/RXI/ERI levels of both SCI channels,
// applies the IPR priority levels and presents one registered request
// (INT_REQ / INT_LVL / INT_VEC) to the CPU core. Register window is
// 0x5FFFF84-0x5FFFF8F on the IBUS.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   CE_R / CE_F       rising / falling clock enables (state on CE_R, read data on CE_F)
//   RES_N             synchronous soft reset, sampled on CE_R
//   NMI_N, IRQ_N[7:0] external interrupt pins, active low
//   SCI0_IRQ, SCI1_IRQ  {TEI,TXI,RXI,ERI} request levels from the SCIs
//   ibus              IBUS slave port (sh7034_intc_if.slave)
//   INT_REQ/LVL/VEC   registered winning request
//   INT_ACK           one CE_R pulse: CPU accepted the current INT_VEC
// ---------------------------------------------------------------------------
module sh7034_intc #(
    parameter logic [7:0] NMI_VEC = 8'd11,
    parameter logic [7:0] IRQ_VEC = 8'd64,
    parameter logic [7:0] SCI_VEC = 8'd128
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic        NMI_N,
    input  logic [7:0]  IRQ_N,
    input  logic [3:0]  SCI0_IRQ,
    input  logic [3:0]  SCI1_IRQ,
    sh7034_intc_if.slave ibus,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [7:0]  INT_VEC,
    input  logic        INT_ACK
);

    logic [15:0] ipra, iprb, iprc, iprd, ipre;
    logic        icr_nmie;
    logic [7:0]  icr_irqs;       // bit 7 = IRQ0S ... bit 0 = IRQ7S
    logic        nmi_s;
    logic [7:0]  irq_s;
    logic        nmi_lat;
    logic [7:0]  irq_lat;
    logic [31:0] reg_do;

    // Bus decode ------------------------------------------------------------
    logic        in_range, sel, wr_en, rd_en;
    logic [2:0]  reg_idx;
    logic [15:0] wdata16, icr_rd;
    logic [1:0]  wbe;
    logic        unused_a0;

    assign in_range = (ibus.IBUS_A[27:4] == 24'h5FFFF8) && (ibus.IBUS_A[3:2] != 2'b00);
    assign sel      = in_range && ibus.IBUS_REQ;
    assign wr_en    = sel && ibus.IBUS_WE;
    assign rd_en    = sel && !ibus.IBUS_WE;
    assign reg_idx  = ibus.IBUS_A[3:1];
    // Halfword at A[1]=0 travels on lanes 3:2, at A[1]=1 on lanes 1:0.
    assign wdata16  = ibus.IBUS_A[1] ? ibus.IBUS_DI[15:0] : ibus.IBUS_DI[31:16];
    assign wbe      = ibus.IBUS_A[1] ? ibus.IBUS_BA[1:0]  : ibus.IBUS_BA[3:2];
    assign icr_rd   = {nmi_s, 6'd0, icr_nmie, icr_irqs};
    assign unused_a0 = ibus.IBUS_A[0];

    assign ibus.IBUS_DO   = sel ? reg_do : 32'd0;
    assign ibus.IBUS_BUSY = 1'b0;
    assign ibus.IBUS_ACT  = in_range;

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  be);
        return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
    endfunction

    // Edge detection and latch next-state -----------------------------------
    logic [7:0] icr_irqs_nx;
    logic [7:0] edge_mode, edge_mode_nx;
    logic [7:0] irq_set, ack_irq, irq_eff, irq_act, irq_lat_nx;
    logic       nmi_set, ack_nmi, nmi_eff, nmi_lat_nx;

    always_comb begin
        icr_irqs_nx = icr_irqs;
        if (wr_en && reg_idx == 3'd7 && wbe[0])
            icr_irqs_nx = wdata16[7:0];

        edge_mode    = '0;
        edge_mode_nx = '0;
        ack_irq      = '0;
        for (int n = 0; n < 8; n++) begin
            edge_mode[n]    = icr_irqs[7-n];
            edge_mode_nx[n] = icr_irqs_nx[7-n];
            ack_irq[n]      = INT_ACK && (INT_VEC == IRQ_VEC + 8'(n)) && icr_irqs[7-n];
        end

        irq_set = irq_s & ~IRQ_N & edge_mode;
        nmi_set = icr_nmie ? (!nmi_s && NMI_N) : (nmi_s && !NMI_N);
        ack_nmi = INT_ACK && (INT_VEC == NMI_VEC);

        // An acknowledged latch drops out of this arbitration unless a fresh
        // edge arrives in the same cycle, so the CPU never sees a stale repeat.
        nmi_eff = nmi_lat && !(ack_nmi && !nmi_set);
        irq_eff = irq_lat & ~(ack_irq & ~irq_set);

        nmi_lat_nx = nmi_eff || nmi_set;
        // Moving a pin to level mode discards any pending edge.
        irq_lat_nx = (irq_eff | irq_set) & edge_mode_nx;

        for (int n = 0; n < 8; n++)
            irq_act[n] = edge_mode[n] ? irq_eff[n] : !irq_s[n];
    end

    // Arbitration -----------------------------------------------------------
    logic [15:0] src_act;
    logic [3:0]  src_lvl [16];
    logic [3:0]  best_lvl;
    logic [7:0]  best_vec;

    always_comb begin
        src_act = {SCI1_IRQ, SCI0_IRQ, irq_act};
        for (int n = 0; n < 4; n++) begin
            src_lvl[n]     = ipra[15-4*n -: 4];
            src_lvl[n+4]   = iprb[15-4*n -: 4];
            src_lvl[n+8]   = iprd[7:4];
            src_lvl[n+12]  = iprd[3:0];
        end
        // Strictly-greater keeps the lowest index on ties; level 0 never wins.
        best_lvl = 4'd0;
        best_vec = INT_VEC;
        for (int i = 0; i < 16; i++) begin
            if (src_act[i] && src_lvl[i] > best_lvl) begin
                best_lvl = src_lvl[i];
                best_vec = (i < 8) ? IRQ_VEC + 8'(i) : SCI_VEC + 8'(i - 8);
            end
        end
    end

    // State -----------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ipra <= '0; iprb <= '0; iprc <= '0; iprd <= '0; ipre <= '0;
            icr_nmie <= 1'b0;
            icr_irqs <= '0;
            nmi_s    <= 1'b1;
            irq_s    <= '1;
            nmi_lat  <= 1'b0;
            irq_lat  <= '0;
            INT_REQ  <= 1'b0;
            INT_LVL  <= '0;
            INT_VEC  <= '0;
            reg_do   <= '0;
        end else if (CE_R && !RES_N) begin
            ipra <= '0; iprb <= '0; iprc <= '0; iprd <= '0; ipre <= '0;
            icr_nmie <= 1'b0;
            icr_irqs <= '0;
            nmi_s    <= 1'b1;
            irq_s    <= '1;
            nmi_lat  <= 1'b0;
            irq_lat  <= '0;
            INT_REQ  <= 1'b0;
            INT_LVL  <= '0;
            INT_VEC  <= '0;
            reg_do   <= '0;
        end else begin
            if (CE_R) begin
                nmi_s   <= NMI_N;
                irq_s   <= IRQ_N;
                nmi_lat <= nmi_lat_nx;
                irq_lat <= irq_lat_nx;

                if (wr_en) begin
                    case (reg_idx)
                        3'd2: ipra <= merge16(ipra, wdata16, wbe);
                        3'd3: iprb <= merge16(iprb, wdata16, wbe);
                        3'd4: iprc <= merge16(iprc, wdata16, wbe);
                        3'd5: iprd <= merge16(iprd, wdata16, wbe);
                        3'd6: ipre <= merge16(ipre, wdata16, wbe);
                        3'd7: begin
                            if (wbe[1]) icr_nmie <= wdata16[8];
                            icr_irqs <= icr_irqs_nx;
                        end
                        default: ;
                    endcase
                end

                if (nmi_eff) begin
                    INT_REQ <= 1'b1;
                    INT_LVL <= 4'd15;
                    INT_VEC <= NMI_VEC;
                end else if (best_lvl != 4'd0) begin
                    INT_REQ <= 1'b1;
                    INT_LVL <= best_lvl;
                    INT_VEC <= best_vec;
                end else begin
                    INT_REQ <= 1'b0;
                    INT_LVL <= 4'd0;
                end
            end

            if (CE_F && rd_en) begin
                case (reg_idx)
                    3'd2: reg_do <= {2{ipra}};
                    3'd3: reg_do <= {2{iprb}};
                    3'd4: reg_do <= {2{iprc}};
                    3'd5: reg_do <= {2{iprd}};
                    3'd6: reg_do <= {2{ipre}};
                    3'd7: reg_do <= {2{icr_rd}};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sh7034_intc.sv
// ---------------------------------------------------------------------------
// tb_sh7034_intc -- directed self-checking bench for sh7034_intc.
// ---------------------------------------------------------------------------
module tb_sh7034_intc;

    // Clock / reset ---------------------------------------------------------
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST_N, CE_R, CE_F, RES_N, NMI_N, INT_ACK;
    logic [7:0] IRQ_N;
    logic [3:0] SCI0_IRQ, SCI1_IRQ;
    logic       INT_REQ;
    logic [3:0] INT_LVL;
    logic [7:0] INT_VEC;

    sh7034_intc_if ibus ();

    sh7034_intc dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CE_R     (CE_R),
        .CE_F     (CE_F),
        .RES_N    (RES_N),
        .NMI_N    (NMI_N),
        .IRQ_N    (IRQ_N),
        .SCI0_IRQ (SCI0_IRQ),
        .SCI1_IRQ (SCI1_IRQ),
        .ibus     (ibus),
        .INT_REQ  (INT_REQ),
        .INT_LVL  (INT_LVL),
        .INT_VEC  (INT_VEC),
        .INT_ACK  (INT_ACK)
    );

    localparam logic [27:0] A_IPRA = 28'h5FFFF84;
    localparam logic [27:0] A_IPRB = 28'h5FFFF86;
    localparam logic [27:0] A_IPRC = 28'h5FFFF88;
    localparam logic [27:0] A_IPRD = 28'h5FFFF8A;
    localparam logic [27:0] A_IPRE = 28'h5FFFF8C;
    localparam logic [27:0] A_ICR  = 28'h5FFFF8E;

    // Scoreboard ------------------------------------------------------------
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        exp_v = exp_q.pop_front();
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] int_word();
        return {19'd0, INT_REQ, INT_LVL, INT_VEC};
    endfunction

    // Push the expected request, allow up to 'budget' CE_R cycles, compare.
    task automatic expect_int(input string tag, input logic req, input logic [3:0] lvl,
                              input logic [7:0] vec, input int budget);
        logic [31:0] e;
        e = {19'd0, req, lvl, vec};
        exp_q.push_back(e);
        for (int i = 0; i < budget && int_word() !== e; i++) tick();
        check(tag, int_word());
    endtask

    // Driver tasks ----------------------------------------------------------
    task automatic wr(input logic [27:0] addr, input logic [31:0] di, input logic [3:0] ba);
        ibus.IBUS_A   = addr;
        ibus.IBUS_DI  = di;
        ibus.IBUS_BA  = ba;
        ibus.IBUS_WE  = 1'b1;
        ibus.IBUS_REQ = 1'b1;
        tick();
        ibus.IBUS_REQ = 1'b0;
        ibus.IBUS_WE  = 1'b0;
        ibus.IBUS_BA  = 4'd0;
    endtask

    task automatic wr16(input logic [27:0] addr, input logic [15:0] val);
        if (addr[1]) wr(addr, {16'h0000, val}, 4'b0011);
        else         wr(addr, {val, 16'h0000}, 4'b1100);
    endtask

    task automatic rd(input string tag, input logic [27:0] addr, input logic [31:0] exp_v);
        exp_q.push_back(exp_v);
        ibus.IBUS_A   = addr;
        ibus.IBUS_WE  = 1'b0;
        ibus.IBUS_REQ = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check(tag, ibus.IBUS_DO);
        ibus.IBUS_REQ = 1'b0;
        tick();
    endtask

    task automatic ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic pulse_irq5();
        IRQ_N[5] = 1'b0;
        tick();
        IRQ_N[5] = 1'b1;
    endtask

    // Watchdog --------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Directed sequence -----------------------------------------------------
    initial begin
        RST_N = 1'b0; RES_N = 1'b1; CE_R = 1'b1; CE_F = 1'b1;
        NMI_N = 1'b1; IRQ_N = 8'hFF; SCI0_IRQ = 4'd0; SCI1_IRQ = 4'd0; INT_ACK = 1'b0;
        ibus.IBUS_A = 28'd0; ibus.IBUS_DI = 32'd0; ibus.IBUS_BA = 4'd0;
        ibus.IBUS_WE = 1'b0; ibus.IBUS_REQ = 1'b0;
        tick(3);
        RST_N = 1'b1;

        // Reset state
        expect_int("reset_int", 1'b0, 4'd0, 8'd0, 0);
        rd("reset_ipra", A_IPRA, 32'h0000_0000);
        rd("reset_iprb", A_IPRB, 32'h0000_0000);
        rd("reset_iprc", A_IPRC, 32'h0000_0000);
        rd("reset_iprd", A_IPRD, 32'h0000_0000);
        rd("reset_ipre", A_IPRE, 32'h0000_0000);
        rd("reset_icr",  A_ICR,  32'h8000_8000);

        // Window decode and deselected read data
        exp_q.push_back(32'd1);
        ibus.IBUS_A = A_IPRA; #1;
        check("act_in_range", {31'd0, ibus.IBUS_ACT});
        exp_q.push_back(32'd0);
        check("do_unselected", ibus.IBUS_DO);
        exp_q.push_back(32'd0);
        ibus.IBUS_A = 28'h5FFFF80; #1;
        check("act_below", {31'd0, ibus.IBUS_ACT});
        exp_q.push_back(32'd0);
        ibus.IBUS_A = 28'h5FFFF90; #1;
        check("act_above", {31'd0, ibus.IBUS_ACT});
        exp_q.push_back(32'd0);
        check("busy", {31'd0, ibus.IBUS_BUSY});

        // Byte-lane write: only the MSB lane of IPRC
        wr(A_IPRC, 32'hABCD_0000, 4'b1000);
        rd("iprc_byte", A_IPRC, 32'hAB00_AB00);

        // SCI0 RXI at level 5
        wr16(A_IPRD, 16'h0050);
        rd("iprd_rb", A_IPRD, 32'h0050_0050);
        SCI0_IRQ = 4'b0010;
        expect_int("sci0_rxi", 1'b1, 4'd5, 8'd129, 3);
        SCI0_IRQ = 4'b0000;
        expect_int("sci0_drop", 1'b0, 4'd0, 8'd129, 3);

        // Without CE_R nothing moves
        CE_R = 1'b0;
        SCI0_IRQ = 4'b0010;
        tick(3);
        expect_int("ce_r_gated", 1'b0, 4'd0, 8'd129, 0);
        CE_R = 1'b1;
        expect_int("ce_r_resume", 1'b1, 4'd5, 8'd129, 3);
        SCI0_IRQ = 4'b0000;

        // SCI1 at level 3 vs SCI0 at level 5
        wr16(A_IPRD, 16'h0053);
        SCI1_IRQ = 4'b0001;
        expect_int("sci1_eri", 1'b1, 4'd3, 8'd132, 3);
        SCI0_IRQ = 4'b1000;
        expect_int("sci0_tei_wins", 1'b1, 4'd5, 8'd131, 3);
        SCI0_IRQ = 4'b0000; SCI1_IRQ = 4'b0000;
        wr16(A_IPRD, 16'h0000);
        expect_int("sci_idle", 1'b0, 4'd0, 8'd131, 3);

        // Level IRQ0/IRQ1, priority then tie
        wr16(A_IPRA, 16'h3700);
        IRQ_N[0] = 1'b0; IRQ_N[1] = 1'b0;
        expect_int("irq1_higher", 1'b1, 4'd7, 8'd65, 4);
        wr16(A_IPRA, 16'h7700);
        expect_int("irq0_tie", 1'b1, 4'd7, 8'd64, 3);
        IRQ_N[0] = 1'b1; IRQ_N[1] = 1'b1;
        expect_int("irq_release", 1'b0, 4'd0, 8'd64, 4);

        // IRQ5 edge mode; its priority field is IPRB[11:8]
        wr16(A_ICR, 16'h0004);
        wr16(A_IPRB, 16'h0200);
        rd("icr_rb", A_ICR, 32'h8004_8004);
        pulse_irq5();
        expect_int("irq5_edge", 1'b1, 4'd2, 8'd69, 3);
        tick(5);
        expect_int("irq5_held", 1'b1, 4'd2, 8'd69, 0);
        ack();
        expect_int("irq5_acked", 1'b0, 4'd0, 8'd69, 3);

        // New edge coincident with the acknowledge keeps the request
        pulse_irq5();
        expect_int("irq5_edge2", 1'b1, 4'd2, 8'd69, 3);
        IRQ_N[5] = 1'b0; INT_ACK = 1'b1;
        tick();
        IRQ_N[5] = 1'b1; INT_ACK = 1'b0;
        tick(2);
        expect_int("irq5_ack_edge", 1'b1, 4'd2, 8'd69, 0);
        ack();
        expect_int("irq5_acked2", 1'b0, 4'd0, 8'd69, 3);

        // NMI pre-empts a level-15 IRQ0, ack reverts to it
        wr16(A_IPRA, 16'hF000);
        IRQ_N[0] = 1'b0;
        expect_int("irq0_lvl15", 1'b1, 4'd15, 8'd64, 4);
        NMI_N = 1'b0;
        expect_int("nmi", 1'b1, 4'd15, 8'd11, 4);
        rd("icr_nmil_low", A_ICR, 32'h0004_0004);
        ack();
        expect_int("nmi_acked", 1'b1, 4'd15, 8'd64, 2);
        NMI_N = 1'b1;
        tick(3);
        expect_int("nmi_rise_ignored", 1'b1, 4'd15, 8'd64, 0);
        IRQ_N[0] = 1'b1;
        expect_int("irq0_release", 1'b0, 4'd0, 8'd64, 4);

        // Edge -> level switch discards the pending IRQ5 edge
        pulse_irq5();
        expect_int("irq5_edge3", 1'b1, 4'd2, 8'd69, 3);
        wr16(A_ICR, 16'h0000);
        expect_int("irq5_to_level", 1'b0, 4'd0, 8'd69, 3);

        // Soft reset in the middle of a request
        IRQ_N[0] = 1'b0;
        expect_int("pre_res", 1'b1, 4'd15, 8'd64, 4);
        RES_N = 1'b0;
        tick();
        expect_int("res_int", 1'b0, 4'd0, 8'd0, 0);
        tick();
        RES_N = 1'b1;
        tick(2);
        expect_int("post_res_int", 1'b0, 4'd0, 8'd0, 0);
        rd("post_res_ipra", A_IPRA, 32'h0000_0000);
        rd("post_res_iprc", A_IPRC, 32'h0000_0000);
        IRQ_N[0] = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
